// File: rtl/ddr3_wfifo_packer.sv
// Packs a 16-bit pixel stream into 128-bit DDR3 write words and buffers them in a
// show-ahead FIFO feeding the MIG write-data port; a wr_load rising edge flushes everything.
module ddr3_wfifo_packer #(
  parameter int unsigned PIX_W = 16,
  parameter int unsigned PACK  = 8,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned CNT_W = 10
) (
  input  logic                   ui_clk,
  input  logic                   rst_n,
  input  logic                   wr_load,
  input  logic                   pix_en,
  input  logic [PIX_W-1:0]       pix_data,
  input  logic                   app_wdf_wren,
  output logic [PIX_W*PACK-1:0]  app_wdf_data,
  output logic [PIX_W*PACK/8-1:0] app_wdf_mask,
  output logic [CNT_W-1:0]       wfifo_rcount,
  output logic                   wfifo_full,
  output logic                   wfifo_empty,
  output logic                   wfifo_ovf,
  output logic                   wfifo_udf
);

  localparam int unsigned DATA_W = PIX_W * PACK;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PCW    = $clog2(PACK);

  logic              wl_d0_q, wl_d1_q, flush_q;
  logic [PCW-1:0]    pix_cnt_q, pix_cnt_d;
  logic [DATA_W-1:0] pack_q, pack_d;
  logic              push_q, push_d;
  logic [DATA_W-1:0] push_word_q, push_word_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              push_ok, pop_ok;
  logic [DATA_W-1:0] mem [DEPTH];

  // Pixel packer: lane k gets pixel k; a flush restarts the word at lane 0.
  always_comb begin
    pack_d      = pack_q;
    pix_cnt_d   = pix_cnt_q;
    push_d      = 1'b0;
    push_word_d = push_word_q;
    if (flush_q) begin
      pix_cnt_d = '0;
      if (pix_en) begin
        pack_d[PIX_W-1:0] = pix_data;
        pix_cnt_d         = PCW'(1);
      end
    end else if (pix_en) begin
      for (int k = 0; k < int'(PACK); k++) begin
        if (PCW'(k) == pix_cnt_q) pack_d[k*PIX_W +: PIX_W] = pix_data;
      end
      pix_cnt_d = pix_cnt_q + PCW'(1);
      if (pix_cnt_q == PCW'(PACK - 1)) begin
        push_d      = 1'b1;
        push_word_d = pack_d;
      end
    end
  end

  // FIFO bookkeeping: a pop frees a slot for a same-cycle push at full.
  always_comb begin
    pop_ok   = app_wdf_wren && !empty_q && !flush_q;
    push_ok  = push_q && !flush_q && (!full_q || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush_q) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
      if (push_q && !push_ok)        ovf_d = 1'b1;
      if (app_wdf_wren && empty_q)   udf_d = 1'b1;
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      wl_d0_q     <= 1'b0;
      wl_d1_q     <= 1'b0;
      flush_q     <= 1'b0;
      pix_cnt_q   <= '0;
      pack_q      <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      wl_d0_q     <= wr_load;
      wl_d1_q     <= wl_d0_q;
      flush_q     <= wl_d0_q & ~wl_d1_q;
      pix_cnt_q   <= pix_cnt_d;
      pack_q      <= pack_d;
      push_q      <= push_d;
      push_word_q <= push_word_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  // Storage array carries no reset; contents are meaningless while count is 0.
  always_ff @(posedge ui_clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_word_q;
  end

  assign app_wdf_data = mem[rd_ptr_q];
  assign app_wdf_mask = '0;
  assign wfifo_rcount = count_q;
  assign wfifo_full   = full_q;
  assign wfifo_empty  = empty_q;
  assign wfifo_ovf    = ovf_q;
  assign wfifo_udf    = udf_q;

endmodule

// File: tb/tb_ddr3_wfifo_packer.sv
// Randomized bench for ddr3_wfifo_packer with a queue-based reference model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_ddr3_wfifo_packer;

  logic         ui_clk = 1'b0;
  logic         rst_n  = 1'b1;
  logic         wr_load = 1'b0;
  logic         pix_en = 1'b0;
  logic [15:0]  pix_data = '0;
  logic         app_wdf_wren = 1'b0;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic [9:0]   wfifo_rcount;
  logic         wfifo_full, wfifo_empty, wfifo_ovf, wfifo_udf;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  ddr3_wfifo_packer dut (
    .ui_clk(ui_clk), .rst_n(rst_n), .wr_load(wr_load), .pix_en(pix_en),
    .pix_data(pix_data), .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .wfifo_rcount(wfifo_rcount), .wfifo_full(wfifo_full),
    .wfifo_empty(wfifo_empty), .wfifo_ovf(wfifo_ovf), .wfifo_udf(wfifo_udf)
  );

  always #5 ui_clk = ~ui_clk;

  // Reference model: pixel list, pending word, word queue, sticky flags.
  logic [15:0]  m_part[$];
  logic [127:0] m_q[$];
  bit           m_pend;
  logic [127:0] m_pend_w;
  bit           m_ovf, m_udf;
  bit [2:0]     m_wlh;

  always @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_part.delete(); m_q.delete();
      m_pend = 0; m_pend_w = '0; m_ovf = 0; m_udf = 0; m_wlh = '0;
    end else begin
      bit           fl, np;
      logic [127:0] nw;
      fl = m_wlh[1] && !m_wlh[2];
      m_wlh = {m_wlh[1:0], wr_load};
      np = 0; nw = '0;
      if (fl) begin
        m_q.delete(); m_part.delete(); m_ovf = 0; m_udf = 0;
        if (pix_en) m_part.push_back(pix_data);
      end else begin
        if (app_wdf_wren) begin
          if (m_q.size() == 0) m_udf = 1;
          else void'(m_q.pop_front());
        end
        if (m_pend) begin
          if (m_q.size() < 512) m_q.push_back(m_pend_w);
          else m_ovf = 1;
        end
        if (pix_en) begin
          m_part.push_back(pix_data);
          if (m_part.size() == 8) begin
            for (int k = 0; k < 8; k++) nw[k*16 +: 16] = m_part[k];
            np = 1;
            m_part.delete();
          end
        end
      end
      m_pend = np; m_pend_w = nw;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge ui_clk) begin
    if (chk_en) begin
      chk("rcount", 128'(wfifo_rcount), 128'(m_q.size()));
      chk("full",   128'(wfifo_full),   128'(m_q.size() == 512));
      chk("empty",  128'(wfifo_empty),  128'(m_q.size() == 0));
      chk("ovf",    128'(wfifo_ovf),    128'(m_ovf));
      chk("udf",    128'(wfifo_udf),    128'(m_udf));
      chk("mask",   128'(app_wdf_mask), 128'(0));
      if (m_q.size() != 0) chk("data", app_wdf_data, m_q[0]);
    end
  end

  task automatic tick();
    @(posedge ui_clk);
    #2;
  endtask

  task automatic do_reset();
    pix_en = 0; app_wdf_wren = 0; wr_load = 0;
    rst_n = 0;
    for (int i = 0; i < 4; i++) begin
      pix_en = i[0]; pix_data = 16'(i + 16'h55);
      tick();
    end
    chk("rst_rcount", 128'(wfifo_rcount), 128'(0));
    chk("rst_empty",  128'(wfifo_empty),  128'(1));
    pix_en = 0;
    rst_n = 1;
    tick();
  endtask

  task automatic send_word(input logic [15:0] base);
    for (int k = 0; k < 8; k++) begin
      pix_en = 1; pix_data = base + 16'(k);
      tick();
    end
    pix_en = 0;
  endtask

  task automatic rand_run(input int cycles, input int pen, input int pwr, input int pwl);
    for (int i = 0; i < cycles; i++) begin
      pix_en       = ($urandom_range(99) < pen);
      pix_data     = 16'($urandom);
      app_wdf_wren = ($urandom_range(99) < pwr);
      if ($urandom_range(999) < pwl) wr_load = ~wr_load;
      tick();
    end
    pix_en = 0; app_wdf_wren = 0;
  endtask

  initial begin
    #1 rst_n = 0;
    chk_en = 1;
    // 1: reset with pix_en toggling
    do_reset();
    chk("t1_rcount", 128'(wfifo_rcount), 128'(0));
    chk("t1_full",   128'(wfifo_full),   128'(0));
    chk("t1_ovf",    128'(wfifo_ovf),    128'(0));
    chk("t1_udf",    128'(wfifo_udf),    128'(0));

    // 2: eight pixels 1..8, visible one cycle after the last
    send_word(16'h0001);
    tick();
    chk("t2_rcount", 128'(wfifo_rcount), 128'(1));
    chk("t2_data", app_wdf_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);

    // 3: 513 words, no pops
    do_reset();
    for (int w = 1; w <= 513; w++) send_word(16'(w << 4));
    tick();
    chk("t3_rcount", 128'(wfifo_rcount), 128'(512));
    chk("t3_full",   128'(wfifo_full),   128'(1));
    chk("t3_ovf",    128'(wfifo_ovf),    128'(1));
    chk("t3_head", app_wdf_data, 128'h0017_0016_0015_0014_0013_0012_0011_0010);

    // Random traffic around full
    rand_run(1500, 90, 12, 0);

    // 4: pop coinciding with a push at one word
    do_reset();
    send_word(16'hA000);
    tick();
    send_word(16'hB000);
    app_wdf_wren = 1;
    tick();
    app_wdf_wren = 0;
    chk("t4_rcount", 128'(wfifo_rcount), 128'(1));
    chk("t4_head", app_wdf_data, 128'hB007_B006_B005_B004_B003_B002_B001_B000);
    chk("t4_udf",    128'(wfifo_udf),    128'(0));

    // 5: three stale pixels, then flush, then a fresh word
    for (int k = 0; k < 3; k++) begin
      pix_en = 1; pix_data = 16'hD000 + 16'(k); tick();
    end
    pix_en = 0; wr_load = 1;
    tick(); tick();
    pix_en = 1; pix_data = 16'hC000;
    tick();
    chk("t5_flush_rcount", 128'(wfifo_rcount), 128'(0));
    for (int k = 1; k < 8; k++) begin
      pix_data = 16'hC000 + 16'(k); tick();
    end
    pix_en = 0;
    tick();
    chk("t5_rcount", 128'(wfifo_rcount), 128'(1));
    chk("t5_data", app_wdf_data, 128'hC007_C006_C005_C004_C003_C002_C001_C000);
    tick(); tick(); tick();
    chk("t5_held_rcount", 128'(wfifo_rcount), 128'(1));

    // 6: pop while empty, then cleared by the next flush
    app_wdf_wren = 1; tick(); tick();
    app_wdf_wren = 0;
    chk("t6_udf",    128'(wfifo_udf),    128'(1));
    chk("t6_rcount", 128'(wfifo_rcount), 128'(0));
    wr_load = 0; tick();
    wr_load = 1; tick(); tick(); tick();
    chk("t6_udf_clr", 128'(wfifo_udf), 128'(0));

    // Random traffic with frame starts, then an async reset mid-stream
    rand_run(2000, 70, 10, 20);
    rand_run(300, 95, 0, 0);
    rst_n = 0; pix_en = 1;
    #1;
    chk("mid_rst_rcount", 128'(wfifo_rcount), 128'(0));
    chk("mid_rst_empty",  128'(wfifo_empty),  128'(1));
    tick(); tick();
    rst_n = 1; pix_en = 0;
    rand_run(1500, 60, 8, 10);

    tick();
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
